// File: rtl/serial_add_ctrl_pkg.sv
// serial_add_ctrl shared types and constants.
// Default operand width and per-phase cycle count.
package serial_add_ctrl_pkg;

  localparam int DEF_N     = 4;
  localparam int PHASE_LEN = DEF_N;

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    LOAD_A,
    LOAD_B,
    ADD,
    DONE
  } state_t;

endpackage

// File: rtl/serial_add_ctrl_if.sv
// Control/data bundle between the controller
// and the external 4-bit serial adder.
interface serial_add_ctrl_if;

  logic sa_s_in;
  logic sa_shift;
  logic sa_clr_b;
  logic sa_s_out;

  modport master (
    output sa_s_in,
    output sa_shift,
    output sa_clr_b,
    input  sa_s_out
  );

  modport slave (
    input  sa_s_in,
    input  sa_shift,
    input  sa_clr_b,
    output sa_s_out
  );

endinterface

// File: rtl/serial_add_ctrl_sum_sipo.sv
// Serial-in/parallel-out capture of the adder's sum stream.
// Bits enter at the MSB, so the first captured bit ends up in bit 0.
module sum_sipo #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         clear_b,
  input  logic         en,
  input  logic         s_in,
  output logic [N-1:0] q,
  output logic [N-1:0] nxt
);

  assign nxt = {s_in, q[N-1:1]};

  always_ff @(posedge clk or negedge clear_b) begin
    if (!clear_b) begin
      q <= '0;
    end else if (en) begin
      q <= nxt;
    end
  end

endmodule

// File: rtl/serial_add_ctrl.sv
// Sequences a serial adder: clear, shift in A, shift in B,
// then shift out and capture the N-bit sum.
module serial_add_ctrl
  import serial_add_ctrl_pkg::*;
#(
  parameter int N = DEF_N
) (
  input  logic                   clk,
  input  logic                   clear_b,
  input  logic                   start,
  input  logic [N-1:0]           op_a,
  input  logic [N-1:0]           op_b,
  serial_add_ctrl_if.master      sa,
  output logic                   busy,
  output logic                   done,
  output logic [N-1:0]           sum
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t        state_q;
  state_t        state_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic [N-1:0]  a_q;
  logic [N-1:0]  b_q;
  logic [N-1:0]  sipo_q;
  logic [N-1:0]  sipo_nxt;
  logic          last;

  logic s_in_q;
  logic shift_q;
  logic clr_b_q;
  logic s_in_d;
  logic shift_d;
  logic clr_b_d;
  logic busy_d;
  logic done_d;

  assign last = (cnt_q == LAST);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (start) state_d = CLR;
      end
      CLR: begin
        state_d = LOAD_A;
        cnt_d   = '0;
      end
      LOAD_A: begin
        cnt_d = last ? '0 : cnt_q + 1'b1;
        if (last) state_d = LOAD_B;
      end
      LOAD_B: begin
        cnt_d = last ? '0 : cnt_q + 1'b1;
        if (last) state_d = ADD;
      end
      ADD: begin
        cnt_d = last ? '0 : cnt_q + 1'b1;
        if (last) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they can be registered
  // and still line up with the state they belong to.
  always_comb begin
    s_in_d  = 1'b0;
    shift_d = 1'b0;
    clr_b_d = 1'b1;
    done_d  = 1'b0;
    busy_d  = (state_d != IDLE);
    unique case (1'b1)
      (state_d == CLR): begin
        clr_b_d = 1'b0;
      end
      (state_d == LOAD_A): begin
        shift_d = 1'b1;
        s_in_d  = a_q[cnt_d];
      end
      (state_d == LOAD_B): begin
        shift_d = 1'b1;
        s_in_d  = b_q[cnt_d];
      end
      (state_d == ADD): begin
        shift_d = 1'b1;
      end
      (state_d == DONE): begin
        done_d = 1'b1;
      end
      default: begin
        s_in_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge clear_b) begin
    if (!clear_b) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      s_in_q  <= 1'b0;
      shift_q <= 1'b0;
      clr_b_q <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
      sum     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      s_in_q  <= s_in_d;
      shift_q <= shift_d;
      clr_b_q <= clr_b_d;
      busy    <= busy_d;
      done    <= done_d;
      if (state_q == IDLE && start) begin
        a_q <= op_a;
        b_q <= op_b;
      end
      // Last sum bit arrives on this edge, so take the SIPO's next value.
      if (state_q == ADD && last) begin
        sum <= sipo_nxt;
      end
    end
  end

  sum_sipo #(
    .N(N)
  ) u_sipo (
    .clk     (clk),
    .clear_b (clear_b),
    .en      (state_q == ADD),
    .s_in    (sa.sa_s_out),
    .q       (sipo_q),
    .nxt     (sipo_nxt)
  );

  assign sa.sa_s_in  = s_in_q;
  assign sa.sa_shift = shift_q;
  assign sa.sa_clr_b = clr_b_q;

endmodule
